// File: rtl/su_pkg.sv
// Shared types and helpers for the su_adder sequencer: state encoding,
// default widths and the unroll-configuration legality check.
package su_pkg;

  localparam int NUM_BITWIDTH  = 5;
  localparam int TILE_BITWIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_PE = 3'd1,
    DRAIN   = 3'd2,
    GAP     = 3'd3,
    FIN     = 3'd4
  } state_t;

  // Product is formed at full double width so e.g. 31*31 cannot alias into range.
  function automatic logic cfg_valid(
    input logic [NUM_BITWIDTH-1:0]  irrel,
    input logic [NUM_BITWIDTH-1:0]  rel,
    input logic [TILE_BITWIDTH-1:0] tiles,
    input int unsigned              col
  );
    logic [2*NUM_BITWIDTH-1:0] prod;
    prod = {{NUM_BITWIDTH{1'b0}}, irrel} * {{NUM_BITWIDTH{1'b0}}, rel};
    return (irrel != '0) && (rel != '0) && (tiles != '0) && (32'(prod) <= col);
  endfunction

endpackage

// File: rtl/su_gap_timer.sv
// Loadable down-counter timing the idle gap between psum drains; expire marks
// the final gap cycle and doubles as the pe_resume strobe request.
module su_gap_timer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(GAP_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(GAP_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/su_adder_ctrl.sv
// Sequencer between the layer controller and the PE array / su_adder pair.
// Optional SU_ADDER_CTRL_PERF_EN adds DRAIN / WAIT_PE cycle counters.
module su_adder_ctrl #(
  parameter int ROW           = 16,
  parameter int COL           = 16,
  parameter int NUM_BITWIDTH  = 5,
  parameter int TILE_BITWIDTH = 8,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_BITWIDTH-1:0]  cfg_irrel_num,
  input  logic [NUM_BITWIDTH-1:0]  cfg_rel_num,
  input  logic [TILE_BITWIDTH-1:0] cfg_tile_num,
  input  logic                     pe_done,
  input  logic                     su_add_finish,
  output logic [NUM_BITWIDTH-1:0]  irrel_num,
  output logic [NUM_BITWIDTH-1:0]  rel_num,
  output logic                     pe_psum_finish,
  output logic                     conv_finish,
  output logic                     pe_resume,
  output logic [TILE_BITWIDTH-1:0] tile_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
`ifdef SU_ADDER_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_drain_cycles,
  output logic [31:0]              perf_wait_cycles
`endif
);

  import su_pkg::*;

  if (ROW < 1 || COL < 1 || GAP_CYCLES < 1) begin : g_param_chk
    $error("su_adder_ctrl: ROW, COL and GAP_CYCLES must be >= 1");
  end

  state_t                   state;
  logic [TILE_BITWIDTH-1:0] tile_num;
  logic                     last_tile;
  logic                     start_ok;
  logic                     gap_load;
  logic                     gap_expire;

  assign last_tile = (tile_idx == tile_num - TILE_BITWIDTH'(1));
  assign start_ok  = start && cfg_valid(cfg_irrel_num, cfg_rel_num, cfg_tile_num, COL);
  assign gap_load  = (state == DRAIN) && su_add_finish && !last_tile;
  assign busy      = (state != IDLE);

  su_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .load  (gap_load),
    .expire(gap_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      irrel_num      <= '0;
      rel_num        <= '0;
      tile_num       <= '0;
      tile_idx       <= '0;
      pe_psum_finish <= 1'b0;
      conv_finish    <= 1'b0;
      pe_resume      <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      pe_resume <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            irrel_num <= cfg_irrel_num;
            rel_num   <= cfg_rel_num;
            tile_num  <= cfg_tile_num;
            tile_idx  <= '0;
            pe_resume <= 1'b1;
            state     <= WAIT_PE;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        WAIT_PE: begin
          if (pe_done) begin
            pe_psum_finish <= 1'b1;
            conv_finish    <= last_tile;
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          // pe_done here is a protocol violation by the PE array and is dropped.
          if (su_add_finish) begin
            pe_psum_finish <= 1'b0;
            conv_finish    <= 1'b0;
            if (last_tile) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              tile_idx <= tile_idx + TILE_BITWIDTH'(1);
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_expire) begin
            pe_resume <= 1'b1;
            state     <= WAIT_PE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SU_ADDER_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_drain_cycles <= '0;
      perf_wait_cycles  <= '0;
    end else if (state == IDLE) begin
      if (start_ok) begin
        perf_drain_cycles <= '0;
        perf_wait_cycles  <= '0;
      end
    end else begin
      if (state == DRAIN && perf_drain_cycles != '1) begin
        perf_drain_cycles <= perf_drain_cycles + 32'd1;
      end
      if (state == WAIT_PE && perf_wait_cycles != '1) begin
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_su_adder_ctrl.sv
// Directed bench for su_adder_ctrl: config rejection, multi-tile drains with
// gap/resume timing, single-tile layer, ignored events and mid-drain reset.
module tb_su_adder_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_irrel_num = '0;
  logic [4:0] cfg_rel_num = '0;
  logic [7:0] cfg_tile_num = '0;
  logic       pe_done = 1'b0;
  logic       su_add_finish = 1'b0;
  logic [4:0] irrel_num;
  logic [4:0] rel_num;
  logic       pe_psum_finish;
  logic       conv_finish;
  logic       pe_resume;
  logic [7:0] tile_idx;
  logic       busy;
  logic       done;
  logic       cfg_err;
`ifdef SU_ADDER_CTRL_PERF_EN
  logic [31:0] perf_drain_cycles;
  logic [31:0] perf_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int resume_seen = 0;
  int done_seen = 0;

  su_adder_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_irrel_num (cfg_irrel_num),
    .cfg_rel_num   (cfg_rel_num),
    .cfg_tile_num  (cfg_tile_num),
    .pe_done       (pe_done),
    .su_add_finish (su_add_finish),
    .irrel_num     (irrel_num),
    .rel_num       (rel_num),
    .pe_psum_finish(pe_psum_finish),
    .conv_finish   (conv_finish),
    .pe_resume     (pe_resume),
    .tile_idx      (tile_idx),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
`ifdef SU_ADDER_CTRL_PERF_EN
    ,
    .perf_drain_cycles(perf_drain_cycles),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Pulses are one cycle wide, so each is seen at exactly one rising edge.
  always @(posedge clk) begin
    if (pe_resume) resume_seen++;
    if (done) done_seen++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int irrel, input int rel, input int tiles);
    cfg_irrel_num = 5'(irrel);
    cfg_rel_num   = 5'(rel);
    cfg_tile_num  = 8'(tiles);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // pe_done, then su_add_finish hi cycles later; optionally pe_done alongside it.
  task automatic drain(input int hi, input logic both, input logic exp_conv, input string tag);
    int hi_cnt;
    int conv_bad;
    hi_cnt = 0;
    conv_bad = 0;
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    for (int k = 0; k < hi; k++) begin
      if (pe_psum_finish === 1'b1) hi_cnt++;
      if (conv_finish !== exp_conv) conv_bad++;
      if (k == hi - 1) begin
        su_add_finish = 1'b1;
        pe_done = both;
      end
      tick();
    end
    su_add_finish = 1'b0;
    pe_done = 1'b0;
    chk({tag, "_psum_high_cycles"}, 32'(hi_cnt), 32'(hi));
    chk({tag, "_conv_level_bad"}, 32'(conv_bad), 32'd0);
    chk({tag, "_psum_drop"}, 32'(pe_psum_finish), 32'd0);
    chk({tag, "_conv_drop"}, 32'(conv_finish), 32'd0);
  endtask

  // Two gap cycles with psum low, then pe_resume in the first WAIT_PE cycle.
  task automatic gap_seq(input int exp_tile, input string tag);
    chk({tag, "_tile_idx"}, 32'(tile_idx), 32'(exp_tile));
    chk({tag, "_gap1_resume"}, 32'(pe_resume), 32'd0);
    tick();
    chk({tag, "_gap2_resume"}, 32'(pe_resume), 32'd0);
    chk({tag, "_gap2_psum"}, 32'(pe_psum_finish), 32'd0);
    tick();
    chk({tag, "_resume"}, 32'(pe_resume), 32'd1);
    chk({tag, "_resume_psum"}, 32'(pe_psum_finish), 32'd0);
  endtask

  initial begin
    int r0;
    int d0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psum", 32'(pe_psum_finish), 32'd0);
    chk("rst_resume", 32'(pe_resume), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_irrel", 32'(irrel_num), 32'd0);
    chk("rst_tile_idx", 32'(tile_idx), 32'd0);
    reset = 1'b1;
    tick();

    // Rejected configurations
    do_start(5, 4, 3);
    chk("bad_prod_cfg_err", 32'(cfg_err), 32'd1);
    chk("bad_prod_busy", 32'(busy), 32'd0);
    tick();
    chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
    do_start(3, 0, 3);
    chk("bad_rel0_cfg_err", 32'(cfg_err), 32'd1);
    tick();
    do_start(31, 31, 2);
    chk("bad_prod_wide_cfg_err", 32'(cfg_err), 32'd1);
    chk("bad_prod_wide_busy", 32'(busy), 32'd0);
    tick();

    // Three-tile layer
    r0 = resume_seen;
    d0 = done_seen;
    do_start(4, 3, 3);
    chk("s3_busy", 32'(busy), 32'd1);
    chk("s3_resume", 32'(pe_resume), 32'd1);
    chk("s3_irrel", 32'(irrel_num), 32'd4);
    chk("s3_rel", 32'(rel_num), 32'd3);
    chk("s3_tile_idx", 32'(tile_idx), 32'd0);

    // Ignored: start while busy, su_add_finish in WAIT_PE
    cfg_irrel_num = 5'd1;
    cfg_rel_num   = 5'd1;
    start = 1'b1;
    su_add_finish = 1'b1;
    tick();
    tick();
    start = 1'b0;
    su_add_finish = 1'b0;
    chk("ign_tile_idx", 32'(tile_idx), 32'd0);
    chk("ign_cfg_err", 32'(cfg_err), 32'd0);
    chk("ign_irrel", 32'(irrel_num), 32'd4);
    chk("ign_psum", 32'(pe_psum_finish), 32'd0);
    chk("ign_busy", 32'(busy), 32'd1);

    drain(214, 1'b0, 1'b0, "d0");
    gap_seq(1, "g0");
    drain(7, 1'b1, 1'b0, "d1");
    gap_seq(2, "g1");
    tick();
    chk("simul_pe_done_dropped", 32'(pe_psum_finish), 32'd0);
    drain(214, 1'b0, 1'b1, "d2");
    chk("d2_done", 32'(done), 32'd1);
    chk("d2_busy_fin", 32'(busy), 32'd1);
    chk("d2_tile_idx", 32'(tile_idx), 32'd2);
    tick();
    chk("d2_done_pulse", 32'(done), 32'd0);
    chk("d2_idle", 32'(busy), 32'd0);
    chk("d2_irrel_kept", 32'(irrel_num), 32'd4);
    chk("d2_rel_kept", 32'(rel_num), 32'd3);
    chk("s3_resume_count", 32'(resume_seen - r0), 32'd3);
    chk("s3_done_count", 32'(done_seen - d0), 32'd1);

    // Single-tile layer: conv_finish on first drain, FIN right after
    do_start(3, 5, 1);
    chk("s1_rel", 32'(rel_num), 32'd5);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("s1_conv", 32'(conv_finish), 32'd1);
    chk("s1_psum", 32'(pe_psum_finish), 32'd1);
    su_add_finish = 1'b1;
    tick();
    su_add_finish = 1'b0;
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_resume", 32'(pe_resume), 32'd0);
    chk("s1_psum_drop", 32'(pe_psum_finish), 32'd0);
    tick();
    chk("s1_idle", 32'(busy), 32'd0);

    // Reset while draining tile 1 of 3
    do_start(2, 2, 3);
    drain(3, 1'b0, 1'b0, "r0");
    gap_seq(1, "rg");
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("rd_psum", 32'(pe_psum_finish), 32'd1);
    chk("rd_tile_idx", 32'(tile_idx), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_psum", 32'(pe_psum_finish), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_tile_idx", 32'(tile_idx), 32'd0);
    chk("ar_irrel", 32'(irrel_num), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    do_start(4, 3, 3);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_tile_idx", 32'(tile_idx), 32'd0);
    chk("rs_irrel", 32'(irrel_num), 32'd4);
    chk("rs_rel", 32'(rel_num), 32'd3);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("rs_conv", 32'(conv_finish), 32'd0);
    chk("rs_psum", 32'(pe_psum_finish), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/su_adder_ctrl.md
Name: su_adder_ctrl

Overview:
Sequencer for the spatial-unrolling adder (su_adder). It latches the irrelevant/relevant unroll configuration and handshakes each PE-array psum drain into su_adder. It counts output tiles and flags the final tile with conv_finish. It sits between the top-level layer controller and the PE array / su_adder pair.

Parameters:
ROW, 16, PE array rows
COL, 16, PE array columns; also the upper bound of irrel_num*rel_num
NUM_BITWIDTH, 5, width of irrel_num / rel_num
TILE_BITWIDTH, 8, width of tile counter
GAP_CYCLES, 2, minimum cycles pe_psum_finish stays low between drains (>=1)

Ports:
clk  in  1  clock
reset  in  1  async active-low reset
start  in  1  one-cycle pulse; begins a layer using cfg_* values
cfg_irrel_num  in  NUM_BITWIDTH  irrelevant-dimension unroll factor
cfg_rel_num  in  NUM_BITWIDTH  relevant-dimension unroll factor
cfg_tile_num  in  TILE_BITWIDTH  number of output tiles in the layer (>=1)
pe_done  in  1  pulse; PE array has finished a tile and psums are stable
su_add_finish  in  1  pulse from su_adder; current drain written to psum GBF
irrel_num  out  NUM_BITWIDTH  latched config to su_adder
rel_num  out  NUM_BITWIDTH  latched config to su_adder
pe_psum_finish  out  1  level; psums ready for su_adder
conv_finish  out  1  level; current drain is the last tile
pe_resume  out  1  pulse; PE array may start the next tile
tile_idx  out  TILE_BITWIDTH  index of the tile being computed/drained
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last drain completes
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Port names are clk and reset.
- Reset values: all outputs are 0; the state is IDLE.
- States: IDLE, WAIT_PE, DRAIN, GAP, FIN.
- IDLE:
  - On start, validate the config: irrel!=0, rel!=0, irrel*rel<=COL, tile_num!=0.
  - If invalid: cfg_err=1 the next cycle and stay in IDLE.
  - If valid: latch irrel_num, rel_num and tile_num, clear tile_idx, pulse pe_resume the next cycle, go to WAIT_PE.
  - The product check uses a full 2*NUM_BITWIDTH product, with no truncation.
- WAIT_PE: on pe_done, go to DRAIN. pe_psum_finish rises the next cycle. conv_finish is driven as (tile_idx==tile_num-1), also from the next cycle.
- DRAIN:
  - pe_psum_finish and conv_finish are held stable until su_add_finish.
  - On su_add_finish, both drop the next cycle.
  - If this was the last tile, go to FIN. Otherwise increment tile_idx and go to GAP.
- GAP: hold pe_psum_finish low for GAP_CYCLES cycles, pulse pe_resume on the final GAP cycle, then go to WAIT_PE.
- FIN: done=1 for one cycle, then IDLE. irrel_num/rel_num keep their values until the next accepted start.
- Simultaneous events:
  - start outside IDLE is ignored, with no cfg_err.
  - pe_done outside WAIT_PE is ignored.
  - su_add_finish outside DRAIN is ignored.
  - pe_done and su_add_finish in the same DRAIN cycle: su_add_finish is taken and pe_done is dropped. The PE array must not raise pe_done before pe_resume.
- Latency: pe_done to pe_psum_finish is 1 cycle. su_add_finish to pe_resume is GAP_CYCLES+1 cycles.
- Reset mid-operation: immediate return to IDLE and all outputs clear. su_adder sees pe_psum_finish fall asynchronously.
- tile_num=1: the first drain has conv_finish=1, and FIN follows directly with no GAP.

Optional Feature:
SU_ADDER_CTRL_PERF_EN.
- Defined: adds outputs perf_drain_cycles and perf_wait_cycles, each 32 bits.
  - perf_drain_cycles counts cycles spent in DRAIN.
  - perf_wait_cycles counts cycles spent in WAIT_PE.
  - Both clear on an accepted start and saturate at all-ones.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package su_pkg:
  - state encoding typedef (IDLE=0, WAIT_PE=1, DRAIN=2, GAP=3, FIN=4)
  - NUM_BITWIDTH and TILE_BITWIDTH constants
  - a cfg_valid function
- One natural sub-module, su_gap_timer: a loadable down-counter that produces the GAP expiry and the pe_resume strobe.

Test Plan:
- Reset during DRAIN (tile 1 of 3): assert reset low -> all outputs 0 immediately. A new start with irrel=4, rel=3 then restarts tile_idx at 0.
- irrel=4, rel=3, tiles=3; pe_done, then su_add_finish 214 cycles later -> pe_psum_finish is high for 214 cycles and low for GAP_CYCLES. conv_finish is high only on the third drain. done pulses once. pe_resume is seen 3 times in total.
- tiles=1, irrel=3, rel=5 -> first drain has conv_finish=1. FIN follows su_add_finish by 1 cycle with no GAP.
- start with irrel=5, rel=4 (product 20>16) -> cfg_err pulse, busy stays 0. start with rel=0 -> cfg_err.
- start while busy, plus su_add_finish injected during WAIT_PE -> both ignored, tile_idx unchanged. pe_done and su_add_finish together in DRAIN -> only su_add_finish is acted on.
